// File: rtl/serdes_frame_aligner.sv
// Receive-side frame aligner for the SerDes serial output.
// Hunts for the SYNC byte and verifies LOCK_CNT correctly spaced syncs before locking.
// While locked, it pushes byte-aligned payload into a show-ahead FIFO with a valid/ready output.
`timescale 1ns/1ps
module serdes_frame_aligner #(
  parameter logic [7:0]  SYNC        = 8'hA5,
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter int unsigned LOCK_CNT    = 3,
  parameter int unsigned MISS_MAX    = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       sclk_i,
  input  logic       rst_i,
  input  logic       data_i,
  input  logic       valid_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       lock_o,
  output logic       sync_err_o,
  output logic       ovf_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  PLEN    = 8'(PAYLOAD_LEN);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_CNT);
  localparam logic [3:0]  MISS_N  = 4'(MISS_MAX);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      byte_cnt_q, byte_cnt_d;
  logic [3:0]      good_cnt_q, good_cnt_d;
  logic [3:0]      miss_cnt_q, miss_cnt_d;
  logic            sync_err_q, sync_err_d;
  logic            ovf_q;
  logic [7:0]      cand;
  logic            is_sync, sync_pos, push_req;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [7:0]      last_q;
  logic            empty, full, pop, wr_en, drop;

  // Framing state: register update with asynchronous clear.
  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Hunt / verify / locked next-state, byte framing and payload push request.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    sync_err_d = 1'b0;
    push_req   = 1'b0;
    cand       = {sr_q[6:0], data_i};
    is_sync    = (cand == SYNC);
    sync_pos   = (byte_cnt_q == PLEN);
    if (valid_i) begin
      sr_d = cand;
      case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d    = VERIFY;
            good_cnt_d = 4'd1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end
        end
        VERIFY, LOCKED: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!sync_pos) begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              push_req   = (state_q == LOCKED);
            end else begin
              byte_cnt_d = '0;
              if (state_q == VERIFY) begin
                if (!is_sync) begin
                  state_d = HUNT;
                end else if (good_cnt_q + 4'd1 == LOCK_N) begin
                  state_d    = LOCKED;
                  miss_cnt_d = '0;
                end else begin
                  good_cnt_d = good_cnt_q + 4'd1;
                end
              end else if (is_sync) begin
                miss_cnt_d = '0;
              end else begin
                sync_err_d = 1'b1;
                if (miss_cnt_q + 4'd1 == MISS_N) state_d = HUNT;
                else miss_cnt_d = miss_cnt_q + 4'd1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // FIFO control; a push into a full FIFO is only accepted when a pop frees the head slot on the same edge.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH_C);
    pop   = !empty && ready_i;
    wr_en = push_req && (!full || pop);
    drop  = push_req && full && !pop;
  end

  // FIFO storage; never reset, since only written slots are ever presented.
  always_ff @(posedge sclk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= cand;
  end

  // FIFO pointers, occupancy, last-popped byte and sticky overflow flag.
  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Output mapping; data_o keeps the last popped byte while the FIFO is empty.
  always_comb begin
    valid_o    = !empty;
    data_o     = empty ? last_q : mem_q[rd_ptr_q];
    lock_o     = (state_q == LOCKED);
    sync_err_o = sync_err_q;
    ovf_o      = ovf_q;
  end

endmodule

// File: doc/serdes_frame_aligner.md
Name: serdes_frame_aligner

Overview:
- Sits directly downstream of the serial output of the SerDes link, on the receive side.
- Consumes the raw serial bitstream and hunts for a sync byte, then locks onto the frame structure: one SYNC byte followed by PAYLOAD_LEN payload bytes.
- Emits byte-aligned payload bytes through a small show-ahead FIFO with a valid/ready handshake.
- Runs on the serial clock only; there is no clock-domain crossing.

Parameters:
- SYNC, 8'hA5, sync byte value.
- PAYLOAD_LEN, 4, payload bytes per frame (1..255).
- LOCK_CNT, 3, consecutive correctly spaced syncs needed to lock, including the first one found in hunt (2..15).
- MISS_MAX, 2, consecutive bad syncs while locked that cause loss of lock (1..15).
- FIFO_DEPTH, 4, output FIFO entries (power of 2).

Ports:
- sclk_i, input, 1, serial clock; all logic is on the rising edge.
- rst_i, input, 1, asynchronous, active-low reset.
- data_i, input, 1, serial data bit, MSB of each byte first.
- valid_i, input, 1, data_i is sampled only on cycles where this is 1.
- data_o, output, 8, payload byte at the FIFO head.
- valid_o, output, 1, FIFO not empty.
- ready_i, input, 1, downstream accepts data_o when valid_o and ready_i are both 1.
- lock_o, output, 1, state is LOCKED.
- sync_err_o, output, 1, one-cycle pulse on a bad sync while LOCKED.
- ovf_o, output, 1, sticky flag: a payload byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=HUNT; shift register, bit_cnt, byte_cnt, good_cnt, miss_cnt and FIFO pointers all cleared.
  - data_o=0, valid_o=0, lock_o=0, sync_err_o=0, ovf_o=0.
  - Reset asserted mid-frame or mid-drain discards all state immediately.
- Bit shifting:
  - On a valid_i cycle, cand={sr[6:0],data_i} and sr<=cand.
  - Cycles with valid_i=0 change no counter or state.
- HUNT:
  - On every valid bit, if cand==SYNC: go to VERIFY with good_cnt=1, bit_cnt=0, byte_cnt=0.
- Byte framing in VERIFY and LOCKED:
  - bit_cnt counts 0..7 on valid bits; a byte completes on the valid bit where bit_cnt==7, and that byte is cand.
  - byte_cnt counts 0..PAYLOAD_LEN. Indices 0..PAYLOAD_LEN-1 are payload; index PAYLOAD_LEN is the sync position, after which byte_cnt wraps to 0.
- VERIFY:
  - Payload bytes are discarded.
  - At the sync position: if cand==SYNC, good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt=0.
  - If cand!=SYNC, return to HUNT; the search restarts on the next valid bit.
- LOCKED:
  - Each completed payload byte is pushed to the FIFO.
  - At the sync position, cand==SYNC sets miss_cnt=0.
  - Otherwise sync_err_o=1 for exactly that cycle and miss_cnt++. When miss_cnt reaches MISS_MAX, go to HUNT with lock_o=0.
  - A byte position is never re-slipped while LOCKED.
- lock_o is registered from the state: it rises on the edge where the LOCK_CNT-th sync completes. The first payload byte of the next frame is the first one pushed.
- FIFO:
  - Show-ahead: data_o is the head entry and valid_o=!empty.
  - A push becomes visible on valid_o the cycle after the edge that sampled the byte's last bit.
  - Pop occurs when valid_o&&ready_i.
  - Simultaneous push and pop is legal at any occupancy, including full; the count is unchanged in that case.
  - Push while full with no pop in the same cycle: the byte is dropped, FIFO contents are unchanged, and ovf_o is set to 1. ovf_o stays set until reset.
  - Leaving LOCKED does not flush the FIFO; the bytes already stored drain normally.
- data_o holds its last value when the FIFO is empty; it is only meaningful while valid_o=1.

Test Plan:
- All tests use the default parameters.
- Reset: hold rst_i=0, toggle data_i/valid_i for 20 cycles -> all outputs 0 and state HUNT. Release rst_i -> outputs stay 0 until lock.
- Lock and stream: 3 junk bits (101), then frames A5,01,02,03,04 / A5,05,06,07,08 / A5,11,22,33,44 / A5,55,66,77,88. Expected:
  - lock_o rises on the edge sampling bit 0 of the third A5.
  - data_o delivers 11,22,33,44,55,66,77,88 in order with ready_i=1.
  - No payload is emitted before lock.
  - Insert valid_i=0 gaps of 1–3 cycles mid-byte -> same output.
- False sync: A5, then 3 payload bytes, then A5 one byte early -> back to HUNT, lock_o stays 0. Follow with 3 correct frames -> lock.
- Loss of lock:
  - Once locked, send one sync as A4 -> sync_err_o pulses for 1 cycle, lock_o stays 1, that frame's payload is still output.
  - Next sync A5, then two consecutive bad syncs (5A, 00) -> two sync_err_o pulses, lock_o falls on the second, no further pushes.
- Overflow and backpressure:
  - Locked, ready_i=0 across 6 payload bytes 01..06 -> FIFO holds 01..04, ovf_o=1, 05 and 06 dropped.
  - Raise ready_i -> 01,02,03,04 output on consecutive cycles, then valid_o=0. ovf_o stays 1 until reset.
  - Full FIFO with ready_i=1 exactly on a push edge -> no drop, count stays 4.
- Reset mid-operation: assert rst_i=0 while locked with 3 bytes in the FIFO and bit_cnt=5 -> valid_o, lock_o, ovf_o and sync_err_o go to 0 immediately, without waiting for a clock edge. After release, relock needs 3 fresh syncs.
